io_request_arbiter: RTL and testbench

- Shares the single I/O port of the CPU's I/O bus bridge (io_read_*/io_write_* interface) between two requesters: port A (CPU execute path) and port B (DMA/debug engine).
- Accepts one transaction at a time, arbitrates round-robin or fixed-priority, holds the bridge's do strobe until it reports done, returns read data and a one-cycle done pulse to the winner.
- Sits between the requesters and the bridge. The bridge then splits unaligned accesses and drives the Avalon I/O slave.

---
 rtl/io_request_arbiter_pkg.sv | 27 ++
 rtl/io_arb_pick.sv | 29 ++
 rtl/io_request_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_io_request_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_request_arbiter_pkg.sv
// Shared types for the two-port I/O request arbiter.
// State, grant and length encodings used by the top and its picker.
package io_request_arbiter_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_READ  = 2'd1,
        STATE_WRITE = 2'd2,
        STATE_GAP   = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    function automatic logic len_legal(input logic [2:0] len);
        return (len == LEN_BYTE) ||
               (len == LEN_HALF) ||
               (len == LEN_WORD);
    endfunction

endpackage

// File: rtl/io_arb_pick.sv
// Combinational winner select between requesters A and B.
// FAIR alternates on contention; otherwise A always wins a tie.
module io_arb_pick
    import io_request_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic   a_do_i,
    input  logic   b_do_i,
    input  grant_e last_grant_i,
    output logic   valid_o,
    output grant_e grant_o
);

    always_comb begin
        valid_o = a_do_i | b_do_i;
        grant_o = GRANT_A;
        unique case (1'b1)
            (a_do_i && b_do_i): begin
                if (FAIR && (last_grant_i == GRANT_A)) begin
                    grant_o = GRANT_B;
                end
            end
            (b_do_i && !a_do_i): grant_o = GRANT_B;
            default:             grant_o = GRANT_A;
        endcase
    end

endmodule

// File: rtl/io_request_arbiter.sv
// Shares the I/O bus bridge between the CPU (A) and DMA/debug (B).
// One transaction at a time; a GAP cycle separates consecutive grants.
module io_request_arbiter
    import io_request_arbiter_pkg::*;
#(
    parameter bit          FAIR          = 1'b1,
    parameter logic [31:0] ILLEGAL_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_do,
    input  logic        a_write,
    input  logic [15:0] a_address,
    input  logic [2:0]  a_length,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    output logic        a_done,
    input  logic        b_do,
    input  logic        b_write,
    input  logic [15:0] b_address,
    input  logic [2:0]  b_length,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_done,
    output logic        io_read_do,
    output logic [15:0] io_read_address,
    output logic [2:0]  io_read_length,
    input  logic [31:0] io_read_data,
    input  logic        io_read_done,
    output logic        io_write_do,
    output logic [15:0] io_write_address,
    output logic [2:0]  io_write_length,
    output logic [31:0] io_write_data,
    input  logic        io_write_done,
    output logic        busy
);

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    grant_e      grant_q, grant_d;
    logic [15:0] addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic        rd_do_q, rd_do_d;
    logic        wr_do_q, wr_do_d;
    logic        busy_q, busy_d;

    logic        req_valid;
    grant_e      pick_grant;
    logic        sel_b;
    logic        sel_write;
    logic [15:0] sel_addr;
    logic [2:0]  sel_len;
    logic [31:0] sel_wdata;

    io_arb_pick #(
        .FAIR(FAIR)
    ) u_pick (
        .a_do_i      (a_do),
        .b_do_i      (b_do),
        .last_grant_i(last_grant_q),
        .valid_o     (req_valid),
        .grant_o     (pick_grant)
    );

    assign sel_b     = (pick_grant == GRANT_B);
    assign sel_write = sel_b ? b_write   : a_write;
    assign sel_addr  = sel_b ? b_address : a_address;
    assign sel_len   = sel_b ? b_length  : a_length;
    assign sel_wdata = sel_b ? b_wdata   : a_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        wdata_d      = wdata_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        a_done_d     = 1'b0;
        b_done_d     = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                if (req_valid) begin
                    last_grant_d = pick_grant;
                    grant_d      = pick_grant;
                    addr_d       = sel_addr;
                    len_d        = sel_len;
                    wdata_d      = sel_wdata;
                    if (!len_legal(sel_len)) begin
                        // Rejected locally: complete at once, never reach the bridge.
                        state_d = STATE_GAP;
                        if (sel_b) begin
                            b_done_d = 1'b1;
                            if (!sel_write) b_rdata_d = ILLEGAL_RDATA;
                        end else begin
                            a_done_d = 1'b1;
                            if (!sel_write) a_rdata_d = ILLEGAL_RDATA;
                        end
                    end else if (sel_write) begin
                        state_d = STATE_WRITE;
                    end else begin
                        state_d = STATE_READ;
                    end
                end
            end
            STATE_READ: begin
                if (io_read_done) begin
                    state_d = STATE_GAP;
                    if (grant_q == GRANT_B) begin
                        b_done_d  = 1'b1;
                        b_rdata_d = io_read_data;
                    end else begin
                        a_done_d  = 1'b1;
                        a_rdata_d = io_read_data;
                    end
                end
            end
            STATE_WRITE: begin
                if (io_write_done) begin
                    state_d = STATE_GAP;
                    if (grant_q == GRANT_B) begin
                        b_done_d = 1'b1;
                    end else begin
                        a_done_d = 1'b1;
                    end
                end
            end
            STATE_GAP: state_d = STATE_IDLE;
            default:   state_d = STATE_IDLE;
        endcase
        rd_do_d = (state_d == STATE_READ);
        wr_do_d = (state_d == STATE_WRITE);
        busy_d  = (state_d != STATE_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_IDLE;
            last_grant_q <= GRANT_B;
            grant_q      <= GRANT_A;
            addr_q       <= '0;
            len_q        <= '0;
            wdata_q      <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            rd_do_q      <= 1'b0;
            wr_do_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            wdata_q      <= wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            a_done_q     <= a_done_d;
            b_done_q     <= b_done_d;
            rd_do_q      <= rd_do_d;
            wr_do_q      <= wr_do_d;
            busy_q       <= busy_d;
        end
    end

    assign a_rdata          = a_rdata_q;
    assign b_rdata          = b_rdata_q;
    assign a_done           = a_done_q;
    assign b_done           = b_done_q;
    assign io_read_do       = rd_do_q;
    assign io_read_address  = addr_q;
    assign io_read_length   = len_q;
    assign io_write_do      = wr_do_q;
    assign io_write_address = addr_q;
    assign io_write_length  = len_q;
    assign io_write_data    = wdata_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_io_request_arbiter.sv
// Bench for io_request_arbiter: vector table, corner sequences, random run.
// A FAIR=0 instance shares the requester inputs for the priority check.
module tb_io_request_arbiter;

    localparam logic [31:0] ILL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_do = 1'b0, a_write = 1'b0;
    logic [15:0] a_address = '0;
    logic [2:0]  a_length = '0;
    logic [31:0] a_wdata = '0;
    logic        b_do = 1'b0, b_write = 1'b0;
    logic [15:0] b_address = '0;
    logic [2:0]  b_length = '0;
    logic [31:0] b_wdata = '0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_done, b_done;
    logic        io_read_do, io_write_do, busy;
    logic [15:0] io_read_address, io_write_address;
    logic [2:0]  io_read_length, io_write_length;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data = '0;
    logic        io_read_done = 1'b0, io_write_done = 1'b0;

    logic [31:0] f0_a_rdata, f0_b_rdata, f0_io_write_data;
    logic        f0_a_done, f0_b_done, f0_io_read_do, f0_io_write_do, f0_busy;
    logic [15:0] f0_io_read_address, f0_io_write_address;
    logic [2:0]  f0_io_read_length, f0_io_write_length;
    logic        f0_rd_done = 1'b0, f0_wr_done = 1'b0;

    always #5 clk = ~clk;

    io_request_arbiter #(.FAIR(1'b1), .ILLEGAL_RDATA(ILL)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_do(a_do), .a_write(a_write), .a_address(a_address),
        .a_length(a_length), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_done(a_done),
        .b_do(b_do), .b_write(b_write), .b_address(b_address),
        .b_length(b_length), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done),
        .io_read_do(io_read_do), .io_read_address(io_read_address),
        .io_read_length(io_read_length), .io_read_data(io_read_data),
        .io_read_done(io_read_done),
        .io_write_do(io_write_do), .io_write_address(io_write_address),
        .io_write_length(io_write_length), .io_write_data(io_write_data),
        .io_write_done(io_write_done), .busy(busy)
    );

    io_request_arbiter #(.FAIR(1'b0), .ILLEGAL_RDATA(ILL)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_do(a_do), .a_write(a_write), .a_address(a_address),
        .a_length(a_length), .a_wdata(a_wdata),
        .a_rdata(f0_a_rdata), .a_done(f0_a_done),
        .b_do(b_do), .b_write(b_write), .b_address(b_address),
        .b_length(b_length), .b_wdata(b_wdata),
        .b_rdata(f0_b_rdata), .b_done(f0_b_done),
        .io_read_do(f0_io_read_do), .io_read_address(f0_io_read_address),
        .io_read_length(f0_io_read_length), .io_read_data(32'h0000_0011),
        .io_read_done(f0_rd_done),
        .io_write_do(f0_io_write_do), .io_write_address(f0_io_write_address),
        .io_write_length(f0_io_write_length), .io_write_data(f0_io_write_data),
        .io_write_done(f0_wr_done), .busy(f0_busy)
    );

    // Fixed one-cycle bridge for the priority instance.
    always @(posedge clk) begin
        #1;
        if (f0_rd_done || f0_wr_done) begin
            f0_rd_done = 1'b0;
            f0_wr_done = 1'b0;
        end else begin
            f0_rd_done = f0_io_read_do;
            f0_wr_done = f0_io_write_do;
        end
    end

    typedef struct {
        bit          req_b;
        bit          wr;
        logic [15:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] br_data;
        int          lat;
        bit          exp_bridge;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    int checks = 0;
    int errors = 0;
    bit br_auto = 1'b0;
    bit br_sampled = 1'b0;
    int br_cnt = 0;
    int br_lat = 1;

    bit          r_do[2], r_wr[2], drop_pend[2];
    logic [15:0] r_ad[2];
    logic [2:0]  r_ln[2];
    logic [31:0] r_wd[2], m_rd[2];
    bit          in_txn, t_legal, t_read;
    int          exp_win, last_win, since;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit len_ok(input logic [2:0] l);
        return (l == 3'd1) || (l == 3'd2) || (l == 3'd4);
    endfunction

    function automatic logic [2:0] rand_len();
        logic [2:0] l;
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) begin
            l = 3'($urandom_range(0, 7));
            if (len_ok(l)) l = 3'd3;
        end else begin
            l = (k < 3) ? 3'd1 : ((k < 5) ? 3'd2 : 3'd4);
        end
        return l;
    endfunction

    task automatic tick();
        br_sampled = io_read_done | io_write_done;
        @(posedge clk);
        #1;
        if (br_auto) begin
            if (io_read_done || io_write_done) begin
                io_read_done = 1'b0;
                io_write_done = 1'b0;
                br_cnt = 0;
            end else if (io_read_do || io_write_do) begin
                br_cnt++;
                if (br_cnt >= br_lat) begin
                    io_read_done = io_read_do;
                    io_write_done = io_write_do;
                    io_read_data = $urandom;
                    br_lat = $urandom_range(1, 3);
                end
            end
        end
    endtask

    task automatic do_reset();
        br_auto = 1'b0;
        br_cnt = 0;
        io_read_done = 1'b0;
        io_write_done = 1'b0;
        a_do = 1'b0;
        b_do = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int hi, dn, odn, wrong, dc;
        bit drop;
        logic [15:0] adr;
        logic [2:0] ln;
        logic [31:0] wd;
        do_reset();
        if (v.req_b) begin
            b_do = 1'b1; b_write = v.wr; b_address = v.addr;
            b_length = v.len; b_wdata = v.wdata;
        end else begin
            a_do = 1'b1; a_write = v.wr; a_address = v.addr;
            a_length = v.len; a_wdata = v.wdata;
        end
        hi = 0; dn = 0; odn = 0; wrong = 0; dc = -1; drop = 0;
        adr = '0; ln = '0; wd = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (drop) begin
                a_do = 1'b0; b_do = 1'b0; drop = 0;
            end
            if (io_read_done || io_write_done) begin
                io_read_done = 1'b0; io_write_done = 1'b0;
            end
            if (v.wr ? io_write_do : io_read_do) begin
                hi++;
                if (hi == 1) begin
                    adr = v.wr ? io_write_address : io_read_address;
                    ln = v.wr ? io_write_length : io_read_length;
                    wd = io_write_data;
                end
                if (hi == v.lat) begin
                    if (v.wr) io_write_done = 1'b1;
                    else begin
                        io_read_done = 1'b1;
                        io_read_data = v.br_data;
                    end
                end
            end
            if (v.wr ? io_read_do : io_write_do) wrong++;
            if (v.req_b ? a_done : b_done) odn++;
            if (v.req_b ? b_done : a_done) begin
                dn++; dc = c; drop = 1;
                chk($sformatf("v%0d_rdata", idx),
                    v.req_b ? b_rdata : a_rdata, v.exp_rdata);
                chk($sformatf("v%0d_other_rdata", idx),
                    v.req_b ? a_rdata : b_rdata, 32'h0);
                chk($sformatf("v%0d_busy_at_done", idx), busy, 1);
            end
            if (dc >= 0 && c == dc + 1)
                chk($sformatf("v%0d_busy_after", idx), busy, 0);
        end
        chk($sformatf("v%0d_do_cycles", idx), hi, v.exp_bridge ? v.lat : 0);
        chk($sformatf("v%0d_done_count", idx), dn, 1);
        chk($sformatf("v%0d_done_cycle", idx), dc, v.exp_bridge ? v.lat : 0);
        chk($sformatf("v%0d_other_done", idx), odn, 0);
        chk($sformatf("v%0d_wrong_strobe", idx), wrong, 0);
        chk($sformatf("v%0d_addr", idx), adr, v.exp_bridge ? v.addr : 16'h0);
        chk($sformatf("v%0d_len", idx), ln, v.exp_bridge ? v.len : 3'd0);
        if (v.wr && v.exp_bridge) chk($sformatf("v%0d_wdata", idx), wd, v.wdata);
    endtask

    task automatic drive();
        a_do = r_do[0]; a_write = r_wr[0]; a_address = r_ad[0];
        a_length = r_ln[0]; a_wdata = r_wd[0];
        b_do = r_do[1]; b_write = r_wr[1]; b_address = r_ad[1];
        b_length = r_ln[1]; b_wdata = r_wd[1];
    endtask

    task automatic rand_cycle();
        bit sdo[2], swr[2], bs;
        logic [15:0] sad[2];
        logic [2:0] sln[2];
        logic [31:0] swd[2];
        int w;
        tick();
        bs = br_sampled;
        for (int i = 0; i < 2; i++) begin
            sdo[i] = r_do[i]; swr[i] = r_wr[i]; sad[i] = r_ad[i];
            sln[i] = r_ln[i]; swd[i] = r_wd[i];
        end
        for (int i = 0; i < 2; i++) begin
            if (drop_pend[i]) begin
                drop_pend[i] = 0;
                if ($urandom_range(0, 3) != 0) r_do[i] = 0;
            end else if (!r_do[i] && $urandom_range(0, 3) == 0) begin
                r_do[i] = 1; r_wr[i] = 1'($urandom_range(0, 1));
                r_ad[i] = 16'($urandom); r_ln[i] = rand_len();
                r_wd[i] = $urandom;
            end
        end
        drive();
        since++;
        chk("r_strobe_excl", io_read_do & io_write_do, 0);
        chk("r_done_excl", a_done & b_done, 0);
        if (in_txn && bs) chk("r_done_after_bridge", a_done | b_done, 1);
        if (!in_txn && (io_read_do | io_write_do | a_done | b_done)) begin
            chk("r_grant_has_req", sdo[0] | sdo[1], 1);
            chk("r_grant_gap", since >= 2, 1);
            if (sdo[0] && sdo[1]) w = (last_win == 0) ? 1 : 0;
            else w = sdo[1] ? 1 : 0;
            last_win = w; exp_win = w;
            t_legal = len_ok(sln[w]); t_read = !swr[w];
            chk("r_grant_bridge", io_read_do | io_write_do, t_legal);
            if (t_legal) begin
                in_txn = 1;
                chk("r_grant_dir", io_read_do, t_read);
                chk("r_grant_addr", t_read ? io_read_address : io_write_address, sad[w]);
                chk("r_grant_len", t_read ? io_read_length : io_write_length, sln[w]);
                if (!t_read) chk("r_grant_wdata", io_write_data, swd[w]);
            end
        end
        if (a_done | b_done) begin
            chk("r_done_who", b_done, exp_win);
            chk("r_done_drops_do", io_read_do | io_write_do, 0);
            if (t_read) m_rd[exp_win] = t_legal ? io_read_data : ILL;
            in_txn = 0; since = 0; drop_pend[exp_win] = 1;
        end
        chk("r_a_rdata", a_rdata, m_rd[0]);
        chk("r_b_rdata", b_rdata, m_rd[1]);
        chk("r_busy", busy, in_txn || since == 0);
    endtask

    initial begin
        int g1[$], g0[$];
        int n;
        vecs[0]  = '{0, 0, 16'h0060, 3'd1, 32'h0, 32'h0000_00AB, 3, 1, 32'h0000_00AB};
        vecs[1]  = '{0, 0, 16'h0100, 3'd2, 32'h0, 32'h0000_BEEF, 1, 1, 32'h0000_BEEF};
        vecs[2]  = '{0, 0, 16'hFFFF, 3'd4, 32'h0, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF};
        vecs[3]  = '{1, 1, 16'h03F9, 3'd4, 32'h1234_5678, 32'h0, 2, 1, 32'h0};
        vecs[4]  = '{0, 1, 16'h0080, 3'd1, 32'h0000_005A, 32'h0, 1, 1, 32'h0};
        vecs[5]  = '{1, 0, 16'h0001, 3'd2, 32'h0, 32'h0000_1234, 4, 1, 32'h0000_1234};
        vecs[6]  = '{0, 0, 16'h0070, 3'd3, 32'h0, 32'h0, 1, 0, ILL};
        vecs[7]  = '{1, 0, 16'h0071, 3'd0, 32'h0, 32'h0, 1, 0, ILL};
        vecs[8]  = '{0, 1, 16'h0072, 3'd7, 32'h0000_0099, 32'h0, 1, 0, 32'h0};
        vecs[9]  = '{1, 0, 16'h0073, 3'd5, 32'h0, 32'h0, 1, 0, ILL};
        vecs[10] = '{0, 0, 16'h0074, 3'd6, 32'h0, 32'h0, 1, 0, ILL};

        #2;
        chk("rst_rd_do", io_read_do, 0);
        chk("rst_wr_do", io_write_do, 0);
        chk("rst_done", {a_done, b_done}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", io_read_address, 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        do_reset();
        a_do = 1; a_write = 0; a_address = 16'h0010; a_length = 3'd4;
        b_do = 1; b_write = 0; b_address = 16'h0020; b_length = 3'd4;
        br_auto = 1;
        for (int c = 0; c < 100 && (g1.size() < 4 || g0.size() < 4); c++) begin
            tick();
            if (a_done) g1.push_back(0);
            if (b_done) g1.push_back(1);
            if (f0_a_done) g0.push_back(0);
            if (f0_b_done) g0.push_back(1);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair1_grant%0d", i), i < g1.size() ? g1[i] : 9, i % 2);
            chk($sformatf("fair0_grant%0d", i), i < g0.size() ? g0[i] : 9, 0);
        end

        do_reset();
        a_do = 1; a_write = 0; a_address = 16'h0234; a_length = 3'd2;
        tick();
        chk("mrst_do_before", io_read_do, 1);
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        chk("mrst_do_dropped", io_read_do, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_no_done", a_done, 0);
        tick();
        chk("mrst_no_done_held", a_done, 0);
        rst_n = 1;
        n = 0;
        while (!io_read_do && n < 5) begin
            tick();
            n++;
        end
        chk("mrst_reissue", io_read_do, 1);
        chk("mrst_latency", n, 1);
        chk("mrst_addr", io_read_address, 16'h0234);
        chk("mrst_len", io_read_length, 3'd2);
        io_read_done = 1; io_read_data = 32'h0000_5A5A;
        tick();
        io_read_done = 0;
        chk("mrst_done", a_done, 1);
        chk("mrst_rdata", a_rdata, 32'h0000_5A5A);
        tick();
        a_do = 0;
        tick();

        do_reset();
        a_do = 1; a_write = 0; a_address = 16'h0044; a_length = 3'd1;
        b_do = 1; b_write = 1; b_address = 16'h0055; b_length = 3'd2;
        b_wdata = 32'h0000_CAFE;
        tick();
        chk("sp_a_first", io_read_do, 1);
        chk("sp_no_write", io_write_do, 0);
        io_write_done = 1;
        tick();
        io_write_done = 0;
        chk("sp_ignored_done", a_done, 0);
        chk("sp_still_reading", io_read_do, 1);
        io_read_done = 1; io_read_data = 32'h0000_0077;
        tick();
        chk("sp_a_done", a_done, 1);
        chk("sp_a_rdata", a_rdata, 32'h0000_0077);
        chk("sp_do_low", io_read_do | io_write_do, 0);
        tick();
        a_do = 0; io_read_done = 0;
        chk("sp_single_pulse", a_done, 0);
        chk("sp_gap_strobes", io_read_do | io_write_do, 0);
        chk("sp_gap_no_b", b_done, 0);
        tick();
        chk("sp_b_write", io_write_do, 1);
        chk("sp_b_no_read", io_read_do, 0);
        chk("sp_b_addr", io_write_address, 16'h0055);
        chk("sp_b_wdata", io_write_data, 32'h0000_CAFE);
        chk("sp_a_quiet", a_done, 0);
        io_write_done = 1;
        tick();
        io_write_done = 0;
        chk("sp_b_done", b_done, 1);
        chk("sp_b_rdata", b_rdata, 32'h0);
        tick();
        b_do = 0;
        tick();

        do_reset();
        for (int i = 0; i < 2; i++) begin
            r_do[i] = 0; r_wr[i] = 0; r_ad[i] = '0; r_ln[i] = '0;
            r_wd[i] = '0; m_rd[i] = '0; drop_pend[i] = 0;
        end
        drive();
        in_txn = 0; t_legal = 0; t_read = 0;
        exp_win = 0; last_win = 1; since = 100;
        br_auto = 1; br_lat = 1;
        for (int c = 0; c < 3000; c++) rand_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
